// File: rtl/subleq_sequencer.sv
// rtl/subleq_sequencer.sv - SUBLEQ bus-master sequencer: fetch A,B,C, read, subtract, write back, branch
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef CTRLWIDTH
`define CTRLWIDTH 4
`endif
`ifndef CTRL_RD_REQ
`define CTRL_RD_REQ 0
`endif
`ifndef CTRL_WR_REQ
`define CTRL_WR_REQ 1
`endif
`ifndef CTRL_RD_READY
`define CTRL_RD_READY 2
`endif
`ifndef CTRL_WR_DONE
`define CTRL_WR_DONE 3
`endif

module subleq_sequencer #(
  parameter int                   DATAWIDTH = `DATAWIDTH,
  parameter int                   CTRLWIDTH = `CTRLWIDTH,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0,
  parameter int                   TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire  [DATAWIDTH-1:0] data,
  output logic [DATAWIDTH-1:0] addr,
  inout  wire  [CTRLWIDTH-1:0] ctrl,
  input  logic                 run,
  output logic [DATAWIDTH-1:0] pc,
  output logic                 halted,
  output logic                 bus_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, BRANCH, GAP, HALT, BUSERR
  } state_t;

  state_t               state, nxt;
  logic                 rd_req, wr_req;
  logic [DATAWIDTH-1:0] op_a, op_b, op_c, mem_a, result;
  logic [TW-1:0]        tcnt;
  logic                 rd_ready, wr_done, handshake, take;
  logic [DATAWIDTH-1:0] diff, pc_next;

  // Only the two request lines are ours; every other control bit is left undriven.
  assign ctrl[`CTRL_RD_REQ] = rd_req;
  assign ctrl[`CTRL_WR_REQ] = wr_req;
  assign rd_ready = ctrl[`CTRL_RD_READY];
  assign wr_done  = ctrl[`CTRL_WR_DONE];
  assign data     = wr_req ? result : 'z;

  assign diff      = data - mem_a;
  assign take      = result[DATAWIDTH-1] || (result == '0);
  assign pc_next   = take ? op_c : pc + DATAWIDTH'(3);
  // First request cycle is ignored: a responder flag may still be high from the last transfer.
  assign handshake = (tcnt != '0) && ((state == WRITE_B) ? wr_done : rd_ready);

  function automatic logic [DATAWIDTH-1:0] req_addr(input state_t s);
    case (s)
      FETCH_A: req_addr = pc;
      FETCH_B: req_addr = pc + DATAWIDTH'(1);
      FETCH_C: req_addr = pc + DATAWIDTH'(2);
      READ_A:  req_addr = op_a;
      default: req_addr = op_b;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      nxt     <= IDLE;
      pc      <= RESET_PC;
      addr    <= '0;
      rd_req  <= 1'b0;
      wr_req  <= 1'b0;
      halted  <= 1'b0;
      bus_err <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_c    <= '0;
      mem_a   <= '0;
      result  <= '0;
      tcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state  <= FETCH_A;
            addr   <= pc;
            rd_req <= 1'b1;
            tcnt   <= '0;
          end
        end
        FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B: begin
          if (handshake) begin
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            state  <= GAP;
            case (state)
              FETCH_A: begin op_a   <= data; nxt <= FETCH_B; end
              FETCH_B: begin op_b   <= data; nxt <= FETCH_C; end
              FETCH_C: begin op_c   <= data; nxt <= READ_A;  end
              READ_A:  begin mem_a  <= data; nxt <= READ_B;  end
              READ_B:  begin result <= diff; nxt <= WRITE_B; end
              default: nxt <= BRANCH;
            endcase
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state   <= BUSERR;
            rd_req  <= 1'b0;
            wr_req  <= 1'b0;
            bus_err <= 1'b1;
            tcnt    <= TW'(TIMEOUT);
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          state <= nxt;
          tcnt  <= '0;
          if (nxt != BRANCH) begin
            addr <= req_addr(nxt);
            if (nxt == WRITE_B) wr_req <= 1'b1;
            else                rd_req <= 1'b1;
          end
        end
        BRANCH: begin
          if (take && (op_c == '1)) begin
            state  <= HALT;
            pc     <= op_c;
            halted <= 1'b1;
          end else begin
            pc <= pc_next;
            if (run) begin
              state  <= FETCH_A;
              addr   <= pc_next;
              rd_req <= 1'b1;
              tcnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_sequencer.sv
// tb/tb_subleq_sequencer.sv - scoreboard bench for subleq_sequencer with a behavioural RAM responder
module tb_subleq_sequencer;
  localparam int DW = 16;
  localparam int RD = 0, WR = 1;

  logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  wire  [DW-1:0] data;
  wire  [3:0]    ctrl;
  logic [DW-1:0] addr, pc;
  logic          halted, bus_err;

  logic          rd_ready = 1'b0, wr_done = 1'b0, drive = 1'b0;
  logic [DW-1:0] tb_data = '0;
  logic [DW-1:0] mem [0:255];
  logic [31:0]   sb_q [$];
  int            total = 0, bad = 0;
  int            lat = 0;
  bit            stale_arm = 0, mute_en = 0;
  logic [DW-1:0] mute_addr = '0;
  int            n_rd, n_wr, low_run, cur_len, last_len;
  bit            gap_valid;
  int            gaps [$];

  assign data    = drive ? tb_data : 'z;
  assign ctrl[2] = rd_ready;
  assign ctrl[3] = wr_done;

  always #5 clk = ~clk;

  subleq_sequencer #(.DATAWIDTH(DW), .CTRLWIDTH(4), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .ctrl(ctrl),
    .run(run), .pc(pc), .halted(halted), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RAM card: answers after lat cycles; can hold a stale ready into a new request or stay mute.
  task responder();
    int cnt;
    bit stale_used;
    logic [31:0] e;
    cnt = 0;
    stale_used = 0;
    forever begin
      @(negedge clk);
      if (!stale_arm) stale_used = 0;
      if (ctrl[RD]) begin
        if (stale_arm && !stale_used) begin
          stale_used = 1;
          cnt = 0;
        end else if (mute_en && addr == mute_addr) begin
          rd_ready = 0; drive = 0;
        end else if (cnt >= lat) begin
          rd_ready = 1; tb_data = mem[addr[7:0]]; drive = 1;
        end else begin
          rd_ready = 0; drive = 0; cnt++;
        end
      end else if (ctrl[WR]) begin
        drive = 0;
        rd_ready = 0;
        if (cnt >= lat) begin
          if (!wr_done) begin
            if (sb_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
              e = sb_q.pop_front();
              chk("wr_addr_data", {addr, data}, e);
            end
            mem[addr[7:0]] = data;
            wr_done = 1;
          end
        end else cnt++;
      end else begin
        cnt = 0;
        wr_done = 0;
        if (stale_arm && !stale_used) begin
          rd_ready = 1; tb_data = 16'h0BAD; drive = 1;
        end else begin
          rd_ready = 0; drive = 0;
        end
      end
    end
  endtask

  task monitor();
    bit pr_rd, pr_wr, pr_any, any;
    pr_rd = 0; pr_wr = 0; pr_any = 0;
    forever begin
      @(negedge clk);
      any = ctrl[RD] | ctrl[WR];
      if (ctrl[RD] && !pr_rd) n_rd++;
      if (ctrl[WR] && !pr_wr) n_wr++;
      if (any && !pr_any && gap_valid) gaps.push_back(low_run);
      if (any) cur_len = pr_any ? cur_len + 1 : 1;
      else begin
        if (pr_any) begin last_len = cur_len; gap_valid = 1; end
        low_run = pr_any ? 1 : low_run + 1;
      end
      pr_rd = ctrl[RD]; pr_wr = ctrl[WR]; pr_any = any;
    end
  endtask

  task clear_stats();
    n_rd = 0; n_wr = 0; low_run = 0; cur_len = 0; last_len = 0; gap_valid = 0;
    gaps.delete();
  endtask

  task do_reset();
    run = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    clear_stats();
  endtask

  task automatic wait_req(input string tag);
    int i;
    for (i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ctrl[RD]) break;
    end
    chk(tag, ctrl[RD], 1);
  endtask

  task automatic wait_pc(input logic [DW-1:0] want, input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (pc == want) break;
    end
    chk(tag, pc, want);
  endtask

  initial begin
    int n, i;
    clear_stats();
    for (int k = 0; k < 256; k++) mem[k] = '0;
    fork
      responder();
      monitor();
    join_none

    repeat (3) @(posedge clk); #1;
    chk("rst_pc", pc, 0);
    chk("rst_addr", addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_reqs", {ctrl[WR], ctrl[RD]}, 0);

    // one positive-result instruction
    mem[0] = 6; mem[1] = 7; mem[2] = 3; mem[3] = 8; mem[4] = 8; mem[5] = 0;
    mem[6] = 1111; mem[7] = 4444;
    rst_n = 1;
    @(posedge clk); #1;
    clear_stats();
    sb_q.push_back({16'd7, 16'd3333});
    run = 1;
    wait_req("t1_start");
    run = 0;
    wait_pc(3, "t1_pc");
    repeat (5) @(posedge clk); #1;
    chk("t1_reads", n_rd, 5);
    chk("t1_writes", n_wr, 1);
    chk("t1_gap_count", gaps.size(), 5);
    n = 0;
    foreach (gaps[k]) if (gaps[k] != 1) n++;
    chk("t1_gaps_not_one", n, 0);
    chk("t1_mem7", mem[7], 3333);

    // branch taken on zero result
    mem[8] = 5;
    clear_stats();
    sb_q.push_back({16'd8, 16'd0});
    run = 1;
    wait_req("t2_start");
    run = 0;
    wait_pc(0, "t2_pc");
    repeat (3) @(posedge clk); #1;
    chk("t2_reads", n_rd, 5);
    chk("t2_writes", n_wr, 1);

    // halt on taken branch to all ones
    mem[0] = 10; mem[1] = 11; mem[2] = 16'hFFFF; mem[10] = 2; mem[11] = 1;
    sb_q.push_back({16'd11, 16'hFFFF});
    run = 1;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (halted) break;
    end
    chk("t3_halted", halted, 1);
    chk("t3_pc", pc, 16'hFFFF);
    chk("t3_mem11", mem[11], 16'hFFFF);
    n = n_rd;
    repeat (20) @(posedge clk); #1;
    chk("t3_no_more_reads", n_rd, n);
    chk("t3_reqs_low", {ctrl[WR], ctrl[RD]}, 0);

    // timeout during FETCH_B
    do_reset();
    chk("t4_halt_cleared", halted, 0);
    mute_en = 1; mute_addr = 1;
    run = 1;
    for (i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus_err) break;
    end
    @(negedge clk); #1;
    chk("t4_bus_err", bus_err, 1);
    chk("t4_rd_req", ctrl[RD], 0);
    chk("t4_pc", pc, 0);
    chk("t4_req_len", last_len, 15);
    repeat (10) @(posedge clk); #1;
    chk("t4_bus_err_sticky", bus_err, 1);
    chk("t4_reads", n_rd, 2);
    mute_en = 0;

    // stale ready at request start, real answer 3 cycles later
    do_reset();
    mem[0] = 12; mem[1] = 13; mem[2] = 6; mem[12] = 100; mem[13] = 50;
    sb_q.push_back({16'd13, 16'hFFCE});
    lat = 3;
    stale_arm = 1;
    repeat (2) @(negedge clk);
    run = 1;
    wait_req("t5_start");
    run = 0;
    wait_pc(6, "t5_pc");
    stale_arm = 0;
    lat = 0;
    chk("t5_mem13", mem[13], 16'hFFCE);

    // reset pulsed during WRITE_B
    do_reset();
    run = 1;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ctrl[WR]) break;
    end
    chk("t6_in_write", ctrl[WR], 1);
    #1 rst_n = 0;
    #1;
    chk("t6_wr_req_async", ctrl[WR], 0);
    chk("t6_pc_async", pc, 0);
    chk("t6_addr_async", addr, 0);
    run = 0;
    @(posedge clk);
    #1 rst_n = 1;
    clear_stats();
    repeat (10) @(posedge clk); #1;
    chk("t6_idle_no_reads", n_rd, 0);
    chk("t6_mem13_kept", mem[13], 16'hFFCE);
    sb_q.push_back({16'd13, 16'hFF6A});
    run = 1;
    wait_req("t6_restart");
    run = 0;
    wait_pc(6, "t6_pc");
    repeat (3) @(posedge clk); #1;
    chk("sb_left", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/subleq_sequencer.md
Name: subleq_sequencer

Overview:
Bus-master control sequencer that executes SUBLEQ instructions by driving the shared data/addr/ctrl bus to the RAM card and any other bus cards. Per instruction it fetches operands A, B and C at PC, PC+1 and PC+2, then reads mem[A] and mem[B]. It writes mem[B]-mem[A] back to B, then branches to C if the result is <= 0, else advances PC by 3. It is the only master on the bus and owns the RD_REQ/WR_REQ lines.

Parameters:
DATAWIDTH, `DATAWIDTH, word and address width of the bus.
CTRLWIDTH, `CTRLWIDTH, control bus width; bit positions come from the `CTRL_* macros.
RESET_PC, 0, PC loaded on reset.
TIMEOUT, 15, maximum cycles to wait for RD_READY/WR_DONE before bus error; counter width is $clog2(TIMEOUT+1).

Ports:
clk  input  1  system clock, all state changes on posedge.
rst_n  input  1  asynchronous, active-low reset.
data  inout  DATAWIDTH  data bus; driven only while WR_REQ is asserted, else high-Z.
addr  output  DATAWIDTH  address bus, registered.
ctrl  inout  CTRLWIDTH  control bus; drives CTRL_RD_REQ and CTRL_WR_REQ, samples CTRL_RD_READY and CTRL_WR_DONE, all other bits high-Z.
run  input  1  level; while high, the sequencer leaves IDLE and executes.
pc  output  DATAWIDTH  current instruction address.
halted  output  1  high in HALT state.
bus_err  output  1  sticky; high in BUSERR state.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, pc=RESET_PC, addr=0, RD_REQ=0, WR_REQ=0, data high-Z, halted=0, bus_err=0, operand/result registers 0, timeout counter 0.
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, BRANCH, GAP, HALT, BUSERR.
- IDLE -> FETCH_A when run=1. The run level is re-checked only at BRANCH; run=0 there returns to IDLE with the new PC kept.
- Bus read state: addr set on entry (FETCH_A=pc, FETCH_B=pc+1, FETCH_C=pc+2, READ_A=opA, READ_B=opB). RD_REQ is held high.
- Read completion: on each posedge with RD_READY=1, capture data into the target register, drop RD_REQ, go to GAP.
- GAP: exactly one cycle with both REQs low, so the responder clears its ready/done flag. Then the next state in order: FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, BRANCH.
- RD_READY/WR_DONE is ignored in the first request cycle. A responder's flag from a previous transaction can still be high on that cycle; acceptance starts from the second cycle of REQ.
- WRITE_B: addr=opB, data=result, WR_REQ=1 until WR_DONE=1 is sampled, then drop WR_REQ and release data in the same edge, then GAP.
- result = memB - memA, modulo 2^DATAWIDTH; it is computed combinationally and registered at READ_B completion.
- BRANCH (one cycle, no bus activity): if result signed <= 0, pc <= opC, else pc <= pc+3 (wraps modulo 2^DATAWIDTH). The same rule applies to pc+1/pc+2 fetch addresses.
- Halt: if the branch is taken and opC == all ones, go to HALT instead of FETCH_A. pc holds all ones and halted=1.
- HALT and BUSERR are terminal: no bus requests; only rst_n leaves them.
- Timeout: the counter clears on entry to each request state and increments each cycle of REQ. Reaching TIMEOUT without a handshake sends the state to BUSERR, drops the REQs, releases data and sets bus_err=1. pc is frozen at the faulting instruction.
- Reset mid-transaction: REQs drop and data goes high-Z immediately (asynchronous); the partial instruction is discarded.
- Self-modifying code is allowed. A write to pc..pc+2 takes effect on the next fetch.

Test Plan:
- Memory 0..7 = 6,7,3,8,8,0,1111,4444, run=1 -> mem[7]=3333; positive result, so pc=3 after BRANCH. Exactly 5 reads and 1 write, each followed by a 1-cycle GAP.
- Instruction at 3 (A=8,B=8,C=0) with mem[8]=5 -> mem[8]=0; branch taken, pc=0.
- Instruction A=10,B=11,C=0xFFFF with mem[10]=2, mem[11]=1 (DATAWIDTH=16) -> mem[11]=0xFFFF, halted=1, pc=0xFFFF, no further requests.
- Responder never raises RD_READY during FETCH_B -> after TIMEOUT=15 cycles bus_err=1, RD_REQ=0, pc unchanged.
- Stale RD_READY=1 held high at request start and then dropped, with the responder answering 3 cycles later -> the sequencer captures only the later value.
- rst_n pulsed low during WRITE_B -> WR_REQ=0 and data=Z in the same cycle; after release, pc=RESET_PC, state IDLE until run=1.
